rgb_saturation: RTL and testbench
=================================

// Module: rgb_saturation
// PURPOSE
//  Pipelined per-pixel colour-saturation adjuster for an RGB video stream.
//  Computes luma Y = ycoe0*R + ycoe1*G + ycoe2*B.
//  Rescales each channel's distance from Y by a runtime gain: C' = Y + (C - Y)*sat.
//  Sits inline in the video filter chain; de/hs/vs are delayed to stay aligned with pixels.
// PARAMETERS
//  PIXEL_WIDTH    8   bits per colour channel; pixel bus is 3*PIXEL_WIDTH
//  COE_FRAC_BITS  6   fractional bits of all coefficients (1.0 = 2**6 = 64)
// PORTS
//  clk           in   1       single clock, all logic on rising edge
//  rst_n         in   1       synchronous reset, active low
//  saturation_i  in   16      unsigned gain, Q(16-F).F (64 = 1.0, 0 = greyscale)
//  ycoe0_i       in   16      unsigned luma coefficient for R, Q.F
//  ycoe1_i       in   16      unsigned luma coefficient for G, Q.F
//  ycoe2_i       in   16      unsigned luma coefficient for B, Q.F
//  di_i          in   3*PW    input pixel {B,G,R}; R at [PW-1:0]
//  de_i          in   1       data enable
//  hs_i          in   1       hsync
//  vs_i          in   1       vsync
//  do_o          out  3*PW    output pixel {B',G',R'}, same packing as di_i
//  de_o          out  1       de_i delayed by LATENCY
//  hs_o          out  1       hs_i delayed by LATENCY
//  vs_o          out  1       vs_i delayed by LATENCY
// BEHAVIOUR
//  - Reset: rst_n=0 at a clock edge clears every pipeline register.
//    Next cycle do_o=0, de_o=0, hs_o=0, vs_o=0.
//    Asserting reset mid-line drops all in-flight pixels; there is no flush.
//  - Fixed LATENCY = 4 clocks from the input sample edge to the outputs; no stalls, no handshake.
//  - The pipeline runs every cycle regardless of de_i; pixels with de_i=0 are still processed.
//  - Coefficients and saturation_i are sampled in stage 1 together with the pixel.
//    A change takes effect on the next pixel; no glitching of in-flight data.
//  - Stage 1: register R,G,B and the products pR=ycoe0*R, pG=ycoe1*G, pB=ycoe2*B.
//    Each product is PW+16 bits unsigned.
//  - Stage 2: Y = (pR+pG+pB) >> F, truncated. Use a sum width of at least PW+18 bits.
//    Clamp: if Y > 2**PW-1 then Y = 2**PW-1.
//  - Stage 3: dC = C - Y, signed PW+1 bits, per channel.
//    mC = dC * sat, signed with sat zero-extended; at least PW+18 bits.
//  - Stage 4: C' = Y + (mC >>> F), an arithmetic (floor) shift, signed.
//    Clamp to [0, 2**PW-1], then register to do_o.
//  - Channels are independent; no cross-channel saturation or hue preservation.
//  - sat=64 is identity whenever the unclamped Y <= 2**PW-1.
//  - sat=0 gives do_o = {Y,Y,Y}.
//  - Sync pass-through: de/hs/vs use a 4-deep shift register, reset to 0, no other modification.
// TESTING  (ycoe0=19, ycoe1=37, ycoe2=9, i.e. 0.299/0.587/0.144 *64; PW=8)
//  1. R=G=B=255, sat=64.
//     Y sum 16575>>6 = 258 clamps to 255 -> do_o={255,255,255} after 4 clks.
//  2. R=200, G=100, B=50 (Y=124), sat=64 -> do_o={50,100,200} (identity).
//  3. Same pixel, sat=0 -> do_o={124,124,124} (greyscale).
//  4. Same pixel, sat=128 -> R'=276 clamps to 255, G'=76, B'=-24 clamps to 0.
//     Expect do_o={0,76,255}.
//  5. Same pixel, sat=32 -> R'=162, G'=112, B'=87 (floor shifts).
//     Expect do_o={87,112,162}.
//  6. Single-cycle de_i/hs_i/vs_i pulses -> each appears on the matching output exactly 4 clks later.
//     Then hold rst_n=0 for one edge mid-stream -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/rgb_saturation.sv
// rgb_saturation: 4-stage pipelined RGB saturation adjuster, C' = Y + (C - Y)*sat, with aligned de/hs/vs
//   clk, rst_n (sync, active low); saturation_i, ycoe0_i..ycoe2_i: Q.F unsigned gains;
//   di_i {B,G,R} in, de_i/hs_i/vs_i in; do_o {B',G',R'} out, de_o/hs_o/vs_o delayed by 4 clocks
module rgb_saturation #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int COE_FRAC_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              saturation_i,
  input  logic [15:0]              ycoe0_i,
  input  logic [15:0]              ycoe1_i,
  input  logic [15:0]              ycoe2_i,
  input  logic [3*PIXEL_WIDTH-1:0] di_i,
  input  logic                     de_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  output logic [3*PIXEL_WIDTH-1:0] do_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o
);
  localparam int PW = PIXEL_WIDTH;
  localparam int F  = COE_FRAC_BITS;
  localparam int PR = PW + 16;
  localparam int SW = PW + 18;
  localparam int MW = PW + 18;
  logic [2:0][15:0]   coe;
  logic [2:0][PW-1:0] c1_q, c2_q;
  logic [2:0][PR-1:0] p1_d, p1_q;
  logic [2:0][MW-1:0] m3_d, m3_q;
  logic [2:0][PW-1:0] o4_d, o4_q;
  logic [15:0]        sat1_q, sat2_q;
  logic [SW-1:0]      sum_d, yf_d;
  logic [PW-1:0]      y2_d, y2_q, y3_q;
  logic [3:0]         de_q, hs_q, vs_q;
  assign coe   = {ycoe2_i, ycoe1_i, ycoe0_i};
  assign sum_d = SW'(p1_q[0]) + SW'(p1_q[1]) + SW'(p1_q[2]);
  assign yf_d  = sum_d >> F;
  // luma can exceed full scale when the coefficients sum above 1.0
  assign y2_d  = |yf_d[SW-1:PW] ? '1 : yf_d[PW-1:0];
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic signed [PW:0]   dc;
    logic signed [MW-1:0] dcx, satx, sh;
    logic signed [MW:0]   t;
    assign p1_d[c] = PR'(coe[c]) * PR'(di_i[c*PW +: PW]);
    assign dc      = $signed({1'b0, c2_q[c]}) - $signed({1'b0, y2_q});
    assign dcx     = MW'(dc);
    assign satx    = $signed({{(MW-16){1'b0}}, sat2_q});
    assign m3_d[c] = dcx * satx;
    // floor shift keeps negative offsets rounding toward -inf
    assign sh      = $signed(m3_q[c]) >>> F;
    assign t       = $signed({{(MW+1-PW){1'b0}}, y3_q}) + {sh[MW-1], sh};
    assign o4_d[c] = t[MW] ? '0 : |t[MW-1:PW] ? '1 : t[PW-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c1_q   <= '0;
      p1_q   <= '0;
      sat1_q <= '0;
      c2_q   <= '0;
      y2_q   <= '0;
      sat2_q <= '0;
      m3_q   <= '0;
      y3_q   <= '0;
      o4_q   <= '0;
      de_q   <= '0;
      hs_q   <= '0;
      vs_q   <= '0;
    end else begin
      c1_q   <= di_i;
      p1_q   <= p1_d;
      sat1_q <= saturation_i;
      c2_q   <= c1_q;
      y2_q   <= y2_d;
      sat2_q <= sat1_q;
      m3_q   <= m3_d;
      y3_q   <= y2_q;
      o4_q   <= o4_d;
      de_q   <= {de_q[2:0], de_i};
      hs_q   <= {hs_q[2:0], hs_i};
      vs_q   <= {vs_q[2:0], vs_i};
    end
  end
  assign do_o = o4_q;
  assign de_o = de_q[3];
  assign hs_o = hs_q[3];
  assign vs_o = vs_q[3];
endmodule

// File: tb/tb_rgb_saturation.sv
// tb_rgb_saturation: directed checks of luma clamp, gain identity/greyscale/boost/reduce, pipelining, sync delay and reset
module tb_rgb_saturation;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] saturation_i = 16'd64;
  logic [15:0] ycoe0_i = 16'd19, ycoe1_i = 16'd37, ycoe2_i = 16'd9;
  logic [23:0] di_i = '0;
  logic        de_i = 0, hs_i = 0, vs_i = 0;
  logic [23:0] do_o;
  logic        de_o, hs_o, vs_o;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  rgb_saturation dut (
    .clk(clk), .rst_n(rst_n), .saturation_i(saturation_i),
    .ycoe0_i(ycoe0_i), .ycoe1_i(ycoe1_i), .ycoe2_i(ycoe2_i),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );
  localparam logic [23:0] PIX = {8'd50, 8'd100, 8'd200};
  task automatic run_pixel(input logic [23:0] px, input logic [15:0] sat, input logic [23:0] exp, input string name);
    @(negedge clk);
    di_i = px;
    saturation_i = sat;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (do_o !== exp) begin
      n_err++;
      $display("FAIL %s: do_o=%h expected %h", name, do_o, exp);
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    di_i = 24'hffffff;
    de_i = 1; hs_i = 1; vs_i = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({do_o, de_o, hs_o, vs_o} !== 27'd0) begin
      n_err++;
      $display("FAIL reset: outputs=%h expected 0", {do_o, de_o, hs_o, vs_o});
    end
    @(negedge clk);
    rst_n = 1;
    de_i = 0; hs_i = 0; vs_i = 0;
  endtask
  task automatic test_luma_clamp;
    run_pixel(24'hffffff, 16'd64, 24'hffffff, "luma_clamp_white");
    run_pixel(24'h000000, 16'd64, 24'h000000, "black");
  endtask
  task automatic test_gains;
    run_pixel(PIX, 16'd64,  {8'd50, 8'd100, 8'd200}, "identity");
    run_pixel(PIX, 16'd0,   {8'd124, 8'd124, 8'd124}, "greyscale");
    run_pixel(PIX, 16'd128, {8'd0, 8'd76, 8'd255}, "boost_clamp");
    run_pixel(PIX, 16'd32,  {8'd87, 8'd112, 8'd162}, "reduce_floor");
  endtask
  task automatic test_back_to_back;
    logic [15:0] sats [4];
    logic [23:0] exps [4];
    sats = '{16'd64, 16'd0, 16'd128, 16'd32};
    exps = '{{8'd50, 8'd100, 8'd200}, {8'd124, 8'd124, 8'd124}, {8'd0, 8'd76, 8'd255}, {8'd87, 8'd112, 8'd162}};
    di_i = PIX;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j >= 4) begin
        n_cmp++;
        if (do_o !== exps[j-4]) begin
          n_err++;
          $display("FAIL back_to_back[%0d]: do_o=%h expected %h", j-4, do_o, exps[j-4]);
        end
      end
      if (j < 4) saturation_i = sats[j];
    end
  endtask
  task automatic test_sync;
    de_i = 0; hs_i = 0; vs_i = 0;
    repeat (5) @(negedge clk);
    for (int j = 0; j < 9; j++) begin
      if ({de_o, hs_o, vs_o} !== {j == 4, j == 5, j == 6}) begin
        n_err++;
        $display("FAIL sync[%0d]: de/hs/vs=%b expected %b", j, {de_o, hs_o, vs_o}, {j == 4, j == 5, j == 6});
      end
      n_cmp++;
      de_i = (j == 0);
      hs_i = (j == 1);
      vs_i = (j == 2);
      @(negedge clk);
    end
  endtask
  task automatic test_reset_midstream;
    @(negedge clk);
    di_i = PIX; saturation_i = 16'd64;
    de_i = 1; hs_i = 1; vs_i = 1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({do_o, de_o, hs_o, vs_o} !== {PIX, 3'b111}) begin
      n_err++;
      $display("FAIL pre_reset_stream: outputs=%h expected %h", {do_o, de_o, hs_o, vs_o}, {PIX, 3'b111});
    end
    rst_n = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({do_o, de_o, hs_o, vs_o} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_midstream: outputs=%h expected 0", {do_o, de_o, hs_o, vs_o});
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({do_o, de_o} !== 25'd0) begin
      n_err++;
      $display("FAIL no_flush: do_o/de_o=%h expected 0", {do_o, de_o});
    end
  endtask
  initial begin
    test_reset;
    test_luma_clamp;
    test_gains;
    test_back_to_back;
    test_sync;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
